portin_buf: RTL and testbench



---
 rtl/portin_buf.sv | 142 ++++++++++++++
 tb/tb_portin_buf.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/portin_buf.sv
// Serial router input port: deserialises frame_n/valid_n/di frames into {addr, payload}
// packets, rejects malformed frames and queues good packets in a first-word-fall-through FIFO.
module portin_buf #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     frame_n,
  input  logic                     valid_n,
  input  logic                     di,
  input  logic                     granted,
  output logic [ADDR_W-1:0]        addr,
  output logic [DATA_W-1:0]        payload,
  output logic                     vld,
  output logic                     err,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW    = $clog2(DEPTH);
  localparam int LW    = PW + 1;
  localparam int AC_W  = $clog2(ADDR_W + 2);
  localparam int PC_W  = $clog2(DATA_W + 2);
  localparam int PKT_W = ADDR_W + DATA_W;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ADDR    = 2'd1;
  localparam logic [1:0] PAYLOAD = 2'd2;

  localparam logic [AC_W-1:0] A_FULL = AC_W'(ADDR_W);
  localparam logic [AC_W-1:0] A_SAT  = AC_W'(ADDR_W + 1);
  localparam logic [PC_W-1:0] P_LAST = PC_W'(DATA_W - 1);
  localparam logic [PC_W-1:0] P_SAT  = PC_W'(DATA_W + 1);
  localparam logic [LW-1:0]   L_FULL = LW'(DEPTH);
  localparam logic [LW-1:0]   L_ONE  = LW'(1);

  logic [1:0]        state;
  logic [AC_W-1:0]   acnt;
  logic [PC_W-1:0]   pcnt;
  logic [ADDR_W-1:0] addr_sr;
  logic [DATA_W-2:0] data_sr;

  logic [PKT_W-1:0]  mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     rd_next;

  logic              in_frame;
  logic              good_len;
  logic              commit;
  logic              pop;
  logic              push;
  logic [PKT_W-1:0]  pkt;

  // Bits shift in from the top, so exactly ADDR_W / DATA_W-1 shifts leave bit 0 at the LSB.
  assign in_frame = (state != IDLE);
  assign good_len = (acnt == A_FULL) && (pcnt == P_LAST);
  assign commit   = in_frame && frame_n && !valid_n && good_len;
  assign pop      = granted && (level != '0);
  assign push     = commit && ((level != L_FULL) || pop);
  assign pkt      = {addr_sr, di, data_sr};
  assign rd_next  = rd_ptr + 1'b1;
  assign vld      = (level != '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      acnt    <= '0;
      pcnt    <= '0;
      addr_sr <= '0;
      data_sr <= '0;
      err     <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (!frame_n) begin
            if (valid_n) begin
              addr_sr <= {di, addr_sr[ADDR_W-1:1]};
              acnt    <= AC_W'(1);
              state   <= ADDR;
            end else begin
              data_sr <= {di, data_sr[DATA_W-2:1]};
              pcnt    <= PC_W'(1);
              state   <= PAYLOAD;
            end
          end
        end
        default: begin
          if (frame_n) begin
            // End bit or abort: either way the frame is over.
            err   <= valid_n || !good_len;
            acnt  <= '0;
            pcnt  <= '0;
            state <= IDLE;
          end else if (valid_n) begin
            if (state == ADDR) begin
              if (acnt < A_FULL) addr_sr <= {di, addr_sr[ADDR_W-1:1]};
              if (acnt != A_SAT) acnt <= acnt + 1'b1;
            end
          end else begin
            if (pcnt < P_LAST) data_sr <= {di, data_sr[DATA_W-2:1]};
            if (pcnt != P_SAT) pcnt <= pcnt + 1'b1;
            state <= PAYLOAD;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= pkt;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      addr     <= '0;
      payload  <= '0;
      drop_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_next;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
      if (commit && !push && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
      // Head register: refill after a pop, or take the packet when it lands in an empty FIFO.
      if (pop) begin
        if (level > L_ONE)  {addr, payload} <= mem[rd_next];
        else if (push)      {addr, payload} <= pkt;
      end else if (push && (level == '0)) begin
        {addr, payload} <= pkt;
      end
    end
  end

endmodule

// File: tb/tb_portin_buf.sv
// Directed bench for portin_buf: a packet-queue model checked every cycle, plus literal pins.
module tb_portin_buf;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 8;

  logic clock = 1'b0, reset = 1'b1, frame_n = 1'b1, valid_n = 1'b1, di = 1'b0, granted = 1'b0;
  logic [ADDR_W-1:0]      addr;
  logic [DATA_W-1:0]      payload;
  logic                   vld, err;
  logic [CNT_W-1:0]       drop_cnt;
  logic [$clog2(DEPTH):0] level;

  portin_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .frame_n(frame_n), .valid_n(valid_n), .di(di),
    .granted(granted), .addr(addr), .payload(payload), .vld(vld), .err(err),
    .drop_cnt(drop_cnt), .level(level)
  );

  always #5 clock = ~clock;

  int nchk = 0, nerr = 0;
  bit chk_en = 1'b0;

  logic [35:0] mq[$];
  logic [35:0] m_last = '0;
  int          m_drop = 0;
  bit          m_err  = 1'b0;
  logic [3:0]  exp3 [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    nchk++;
    if (act !== want) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  // One clock of stimulus; the model advances on the same rising edge.
  task automatic step(input logic fn, input logic vn, input logic d, input logic g,
                      input bit commit, input bit bad, input logic [35:0] pkt);
    frame_n = fn; valid_n = vn; di = d; granted = g;
    @(posedge clock);
    m_err = bad;
    if (g && mq.size() > 0) m_last = mq.pop_front();
    if (commit) begin
      if (mq.size() < DEPTH) mq.push_back(pkt);
      else if (m_drop < (1 << CNT_W) - 1) m_drop++;
    end
    @(negedge clock);
  endtask

  task automatic idle(input logic g);
    step(1'b1, 1'b1, 1'b0, g, 1'b0, 1'b0, '0);
  endtask

  task automatic send_frame(input int na, input logic [3:0] a, input int nd, input logic [31:0] d,
                            input int wait_at, input int nwait, input int abort_at, input logic g_end);
    bit good;
    good = (na == ADDR_W) && (nd == DATA_W);
    for (int i = 0; i < na; i++) step(1'b0, 1'b1, a[i], 1'b0, 1'b0, 1'b0, '0);
    for (int j = 0; j < nd - 1; j++) begin
      if (j == abort_at) begin
        step(1'b1, 1'b1, 1'b0, g_end, 1'b0, 1'b1, '0);
        return;
      end
      if (j == wait_at)
        for (int w = 0; w < nwait; w++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      step(1'b0, 1'b0, d[j], 1'b0, 1'b0, 1'b0, '0);
    end
    step(1'b1, 1'b0, d[nd-1], g_end, good, !good, {a, d});
  endtask

  task automatic model_reset();
    mq.delete();
    m_last = '0;
    m_drop = 0;
    m_err  = 1'b0;
  endtask

  always @(negedge clock) begin
    logic [35:0] head;
    if (chk_en) begin
      head = (mq.size() != 0) ? mq[0] : m_last;
      check("vld",      vld,      (mq.size() != 0));
      check("level",    level,    mq.size());
      check("addr",     addr,     head[35:32]);
      check("payload",  payload,  head[31:0]);
      check("err",      err,      m_err);
      check("drop_cnt", drop_cnt, m_drop);
    end
  end

  initial begin
    exp3 = '{4'd2, 4'd3, 4'd4, 4'd6};
    repeat (2) @(negedge clock);
    check("rst_vld", vld, 0);
    check("rst_level", level, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_addr_payload", {addr, payload}, 0);
    reset = 1'b0;
    chk_en = 1'b1;

    // Single packet, then pop.
    send_frame(4, 4'hA, 32, 32'hDEADBEEF, -1, 0, -1, 1'b0);
    check("t1_vld", vld, 1);
    check("t1_addr", addr, 4'hA);
    check("t1_payload", payload, 32'hDEADBEEF);
    check("t1_level", level, 1);
    idle(1'b1);
    check("t1_pop_vld", vld, 0);
    check("t1_pop_level", level, 0);

    // Five back-to-back frames into a 4-deep FIFO.
    for (int k = 1; k <= 5; k++) send_frame(4, 4'(k), 32, 32'h1000_0000 + k, -1, 0, -1, 1'b0);
    check("t2_level", level, 4);
    check("t2_drop", drop_cnt, 1);
    for (int k = 1; k <= 4; k++) begin
      check("t2_head", addr, k);
      idle(1'b1);
    end
    check("t2_empty", vld, 0);
    check("t2_hold", addr, 4);

    // Commit while full with a simultaneous pop.
    for (int k = 1; k <= 4; k++) send_frame(4, 4'(k), 32, 32'h2000_0000 + k, -1, 0, -1, 1'b0);
    send_frame(4, 4'h6, 32, 32'h6666_0006, -1, 0, -1, 1'b1);
    check("t3_level", level, 4);
    check("t3_drop", drop_cnt, 1);
    for (int k = 0; k < 4; k++) begin
      check("t3_head", addr, exp3[k]);
      idle(1'b1);
    end
    check("t3_tail_payload", payload, 32'h6666_0006);

    // Malformed frames: short payload, short address, abort.
    send_frame(4, 4'h7, 31, 32'h0F0F_0F0F, -1, 0, -1, 1'b0);
    check("t4_err_short_data", err, 1);
    idle(1'b0);
    send_frame(3, 4'h5, 32, 32'hAAAA_5555, -1, 0, -1, 1'b0);
    check("t4_err_short_addr", err, 1);
    idle(1'b0);
    send_frame(4, 4'h8, 32, 32'h1234_0000, -1, 0, 10, 1'b0);
    check("t4_err_abort", err, 1);
    idle(1'b0);
    check("t4_level", level, 0);
    check("t4_drop", drop_cnt, 1);

    // Wait cycles mid-payload.
    send_frame(4, 4'h3, 32, 32'h12345678, 12, 5, -1, 1'b0);
    check("t5_payload", payload, 32'h12345678);
    check("t5_addr", addr, 4'h3);
    idle(1'b1);

    // Asynchronous reset mid-payload with two packets queued.
    send_frame(4, 4'h9, 32, 32'h9999_0009, -1, 0, -1, 1'b0);
    send_frame(4, 4'hB, 32, 32'hBBBB_000B, -1, 0, -1, 1'b0);
    check("t6_level", level, 2);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    for (int j = 0; j < 10; j++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    #2;
    chk_en = 1'b0;
    reset = 1'b1;
    #1;
    check("t6_rst_vld", vld, 0);
    check("t6_rst_level", level, 0);
    check("t6_rst_drop", drop_cnt, 0);
    check("t6_rst_out", {addr, payload}, 0);
    check("t6_rst_err", err, 0);
    model_reset();
    @(negedge clock);
    frame_n = 1'b1; valid_n = 1'b1;
    reset = 1'b0;
    chk_en = 1'b1;
    send_frame(4, 4'h5, 32, 32'hCAFEF00D, -1, 0, -1, 1'b0);
    check("t6_addr", addr, 4'h5);
    check("t6_payload", payload, 32'hCAFEF00D);
    check("t6_level_after", level, 1);
    idle(1'b1);
    idle(1'b0);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
